serial_load_tx: RTL and testbench

//   Parallel-to-serial transmitter driven by the single-cycle debounced load pulse.
//   On an accepted load it captures data_in, shifts it out on sdat/sclk, then pulses slatch.

---
 rtl/serial_load_tx.sv | 143 ++++++++++++++
 tb/tb_serial_load_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_load_tx.sv
// Parallel-to-serial transmitter for a 74HC595-style shift/latch chain.
// A load pulse captures data_in, the frame is shifted out on sdat/sclk, then slatch is strobed.
module serial_load_tx #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             sclk,
  output logic             sdat,
  output logic             slatch,
  output logic             done,
  output logic             overrun
);
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next, shifted;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DW-1:0]    div_cnt_reg, div_cnt_next;
  logic             busy_next, sclk_next, sdat_next, slatch_next, done_next, overrun_next;
  logic             div_end;

  // The bit at the send end of the register is the one currently on sdat.
  function automatic logic send_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  if (MSB_FIRST) begin : g_shift_msb
    assign shifted = {shift_reg[WIDTH-2:0], 1'b0};
  end else begin : g_shift_lsb
    assign shifted = {1'b0, shift_reg[WIDTH-1:1]};
  end

  assign div_end = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      busy        <= 1'b0;
      sclk        <= 1'b0;
      sdat        <= 1'b0;
      slatch      <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      div_cnt_reg <= div_cnt_next;
      busy        <= busy_next;
      sclk        <= sclk_next;
      sdat        <= sdat_next;
      slatch      <= slatch_next;
      done        <= done_next;
      overrun     <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    div_cnt_next = div_cnt_reg;
    busy_next    = busy;
    sclk_next    = sclk;
    sdat_next    = sdat;
    slatch_next  = slatch;
    done_next    = 1'b0;
    overrun_next = overrun;

    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next   = LOW;
          shift_next   = data_in;
          bit_cnt_next = BIT_FIRST;
          div_cnt_next = '0;
          busy_next    = 1'b1;
          sclk_next    = 1'b0;
          sdat_next    = send_bit(data_in);
          slatch_next  = 1'b0;
          overrun_next = 1'b0;
        end
      end
      LOW: begin
        if (div_end) begin
          state_next   = HIGH;
          div_cnt_next = '0;
          sclk_next    = 1'b1;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_cnt_next = '0;
          sclk_next    = 1'b0;
          if (bit_cnt_reg == '0) begin
            state_next  = LATCH;
            sdat_next   = 1'b0;
            slatch_next = 1'b1;
          end else begin
            // Next bit goes out on the falling edge so it settles for a full low phase.
            state_next   = LOW;
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg - 1'b1;
            sdat_next    = send_bit(shifted);
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      LATCH: begin
        if (div_end) begin
          state_next   = IDLE;
          div_cnt_next = '0;
          busy_next    = 1'b0;
          slatch_next  = 1'b0;
          done_next    = 1'b1;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // busy is low only in IDLE, so this never fights the clear on acceptance.
    if (load && busy) overrun_next = 1'b1;
  end
endmodule

// File: tb/tb_serial_load_tx.sv
// Bench for serial_load_tx: three instances (16/4/MSB, 16/4/LSB, 2/1/MSB) observed
// through a selectable monitor; frames are decoded at sclk rises and checked against a reference.
module tb_serial_load_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [1:0]  sel;
  logic [2:0]  load_v, busy_v, sclk_v, sdat_v, slatch_v, done_v, overrun_v;

  int chk  = 0;
  int pass = 0;

  // Results of the last collected frame
  logic [15:0] c_bits;
  int          c_rises, c_busy, c_latch, c_done, c_toggles, c_unstable;
  logic        c_ovr;
  bit          c_timeout;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_load
    assign load_v[gi] = load && (sel == 2'(gi));
  end

  serial_load_tx #(.WIDTH(16), .DIV(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load(load_v[0]), .data_in(data),
    .busy(busy_v[0]), .sclk(sclk_v[0]), .sdat(sdat_v[0]), .slatch(slatch_v[0]),
    .done(done_v[0]), .overrun(overrun_v[0]));

  serial_load_tx #(.WIDTH(16), .DIV(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load(load_v[1]), .data_in(data),
    .busy(busy_v[1]), .sclk(sclk_v[1]), .sdat(sdat_v[1]), .slatch(slatch_v[1]),
    .done(done_v[1]), .overrun(overrun_v[1]));

  serial_load_tx #(.WIDTH(2), .DIV(1), .MSB_FIRST(1'b1)) dut_small (
    .clk(clk), .rst_n(rst_n), .load(load_v[2]), .data_in(data[1:0]),
    .busy(busy_v[2]), .sclk(sclk_v[2]), .sdat(sdat_v[2]), .slatch(slatch_v[2]),
    .done(done_v[2]), .overrun(overrun_v[2]));

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Expected received bit sequence (first received bit ends up in the MSB).
  function automatic logic [15:0] expect_bits(input logic [1:0] s, input logic [15:0] d);
    if (s == 2'd1) return rev16(d);
    if (s == 2'd2) return {14'd0, d[1:0]};
    return d;
  endfunction

  function automatic int expect_busy(input logic [1:0] s);
    if (s == 2'd2) return 2 * 1 * 2 + 1;
    return 2 * 4 * 16 + 4;
  endfunction

  task automatic start(input logic [1:0] s, input logic [15:0] d);
    @(negedge clk);
    sel  = s;
    load = 1'b1;
    data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Watches the selected instance from the first busy cycle until one cycle after done.
  task automatic collect(input int inject_at, input int inject_len, input logic [15:0] inject_data);
    logic prev_sclk, prev_sdat, prev_busy;
    bit   finished;
    c_bits = '0; c_rises = 0; c_busy = 0; c_latch = 0; c_done = 0;
    c_toggles = 0; c_unstable = 0; c_ovr = 1'b0; c_timeout = 1'b1;
    prev_sclk = 1'b0; prev_sdat = sdat_v[sel]; prev_busy = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == inject_at) begin
        load = 1'b1;
        data = inject_data;
      end else if (cyc == inject_at + inject_len) begin
        load = 1'b0;
      end
      if (busy_v[sel]) c_busy++;
      if (slatch_v[sel]) c_latch++;
      if (done_v[sel]) c_done++;
      if (sclk_v[sel] && !prev_sclk) begin
        c_rises++;
        c_bits = {c_bits[14:0], sdat_v[sel]};
      end
      if (busy_v[sel] && prev_busy && sdat_v[sel] != prev_sdat && !(prev_sclk && !sclk_v[sel]))
        c_unstable++;
      if (busy_v[sel] && prev_busy && sclk_v[sel] != prev_sclk) c_toggles++;
      prev_sclk = sclk_v[sel];
      prev_sdat = sdat_v[sel];
      prev_busy = busy_v[sel];
      if (finished) begin
        c_ovr = overrun_v[sel];
        c_timeout = 1'b0;
        break;
      end
      if (done_v[sel]) finished = 1'b1;
      @(negedge clk);
    end
    load = 1'b0;
    $display("frame sel=%0d bits=%h rises=%0d busy=%0d latch=%0d done=%0d ovr=%0b",
             sel, c_bits, c_rises, c_busy, c_latch, c_done, c_ovr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; data = '0; sel = 2'd0;
    repeat (3) @(negedge clk);
    chk++;
    if ({busy_v, sclk_v, sdat_v, slatch_v, done_v, overrun_v} !== 18'h0)
      $display("FAIL reset_outputs: got %h expected 0", {busy_v, sclk_v, sdat_v, slatch_v, done_v, overrun_v});
    else pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk++;
    if ({busy_v, sclk_v, slatch_v, done_v, overrun_v} !== 15'h0)
      $display("FAIL reset_release_idle: got %h expected 0", {busy_v, sclk_v, slatch_v, done_v, overrun_v});
    else pass++;
  endtask

  task automatic test_frame;
    start(2'd0, 16'hA53C);
    collect(-1, 0, 16'h0);
    chk++; if (c_timeout) $display("FAIL frame_timeout: no done within budget"); else pass++;
    chk++; if (c_bits !== 16'hA53C) $display("FAIL frame_bits: got %h expected a53c", c_bits); else pass++;
    chk++; if (c_rises != 16) $display("FAIL frame_rises: got %0d expected 16", c_rises); else pass++;
    chk++; if (c_busy != 132) $display("FAIL frame_busy: got %0d expected 132", c_busy); else pass++;
    chk++; if (c_latch != 4) $display("FAIL frame_latch: got %0d expected 4", c_latch); else pass++;
    chk++; if (c_done != 1) $display("FAIL frame_done: got %0d expected 1", c_done); else pass++;
    chk++; if (c_unstable != 0) $display("FAIL frame_sdat_stable: got %0d changes expected 0", c_unstable); else pass++;
    chk++; if (c_ovr !== 1'b0) $display("FAIL frame_overrun: got %0b expected 0", c_ovr); else pass++;
  endtask

  task automatic test_lsb_first;
    start(2'd1, 16'h0001);
    collect(-1, 0, 16'h0);
    chk++; if (c_bits !== 16'h8000) $display("FAIL lsb_bits: got %h expected 8000", c_bits); else pass++;
    chk++; if (c_rises != 16) $display("FAIL lsb_rises: got %0d expected 16", c_rises); else pass++;
    chk++; if (c_busy != 132) $display("FAIL lsb_busy: got %0d expected 132", c_busy); else pass++;
  endtask

  task automatic test_overrun;
    logic [15:0] d;
    start(2'd0, 16'hA53C);
    collect(10, 1, 16'hFFFF);
    chk++; if (c_bits !== 16'hA53C) $display("FAIL overrun_bits: got %h expected a53c", c_bits); else pass++;
    chk++; if (c_ovr !== 1'b1) $display("FAIL overrun_set: got %0b expected 1", c_ovr); else pass++;
    repeat (3) @(negedge clk);
    chk++; if (overrun_v[0] !== 1'b1) $display("FAIL overrun_sticky: got %0b expected 1", overrun_v[0]); else pass++;
    d = 16'($urandom);
    start(2'd0, d);
    chk++; if (overrun_v[0] !== 1'b0) $display("FAIL overrun_clear: got %0b expected 0", overrun_v[0]); else pass++;
    collect(-1, 0, 16'h0);
    chk++; if (c_bits !== d) $display("FAIL overrun_next_bits: got %h expected %h", c_bits, d); else pass++;
  endtask

  task automatic test_held_load;
    logic [15:0] d;
    d = 16'($urandom);
    @(negedge clk);
    sel = 2'd0; load = 1'b1; data = d;
    @(negedge clk);
    data = ~d;
    @(negedge clk);
    load = 1'b0;
    collect(-1, 0, 16'h0);
    chk++; if (c_bits !== d) $display("FAIL held_bits: got %h expected %h", c_bits, d); else pass++;
    chk++; if (c_ovr !== 1'b1) $display("FAIL held_overrun: got %0b expected 1", c_ovr); else pass++;
    chk++; if (c_busy != 131) $display("FAIL held_busy: got %0d expected 131", c_busy); else pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d1, d2;
    bit got;
    d1 = 16'($urandom); d2 = 16'($urandom);
    start(2'd0, d1);
    got = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done_v[0]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk++; if (!got) $display("FAIL b2b_done_seen: got 0 expected 1"); else pass++;
    load = 1'b1; data = d2;
    @(negedge clk);
    load = 1'b0;
    chk++;
    if ({busy_v[0], sclk_v[0], overrun_v[0]} !== 3'b100)
      $display("FAIL b2b_start: got busy/sclk/ovr=%b expected 100", {busy_v[0], sclk_v[0], overrun_v[0]});
    else pass++;
    collect(-1, 0, 16'h0);
    chk++; if (c_bits !== d2) $display("FAIL b2b_bits: got %h expected %h", c_bits, d2); else pass++;
    chk++; if (c_busy != 132) $display("FAIL b2b_busy: got %0d expected 132", c_busy); else pass++;
  endtask

  task automatic test_small;
    start(2'd2, 16'h0002);
    collect(-1, 0, 16'h0);
    chk++; if (c_bits[1:0] !== 2'b10 || c_rises != 2)
      $display("FAIL small_bits: got %b/%0d rises expected 10/2", c_bits[1:0], c_rises); else pass++;
    chk++; if (c_busy != 5) $display("FAIL small_busy: got %0d expected 5", c_busy); else pass++;
    chk++; if (c_toggles != 4) $display("FAIL small_toggles: got %0d expected 4", c_toggles); else pass++;
    chk++; if (c_latch != 1 || c_done != 1)
      $display("FAIL small_latch_done: got %0d/%0d expected 1/1", c_latch, c_done); else pass++;
  endtask

  task automatic test_reset_midframe;
    int   r, stray;
    logic p;
    bit   got;
    logic [15:0] d;
    start(2'd0, 16'h5AC3);
    r = 0; p = 1'b0; got = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      load = (cyc == 3);
      if (sclk_v[0] && !p) r++;
      p = sclk_v[0];
      if (r == 5) begin got = 1'b1; break; end
      @(negedge clk);
    end
    load = 1'b0;
    chk++; if (!got || overrun_v[0] !== 1'b1)
      $display("FAIL midreset_setup: got rises=%0d ovr=%0b expected 5/1", r, overrun_v[0]); else pass++;
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if ({busy_v, sclk_v, sdat_v, slatch_v, done_v, overrun_v} !== 18'h0)
      $display("FAIL midreset_async: got %h expected 0", {busy_v, sclk_v, sdat_v, slatch_v, done_v, overrun_v});
    else pass++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_v[0] || done_v[0] || slatch_v[0] || sclk_v[0]) stray++;
    end
    chk++; if (stray != 0) $display("FAIL midreset_idle: got %0d active cycles expected 0", stray); else pass++;
    d = 16'($urandom);
    start(2'd0, d);
    collect(-1, 0, 16'h0);
    chk++; if (c_bits !== d) $display("FAIL midreset_next_bits: got %h expected %h", c_bits, d); else pass++;
  endtask

  task automatic test_random;
    logic [1:0]  s;
    logic [15:0] d;
    for (int n = 0; n < 6; n++) begin
      s = 2'($urandom_range(0, 2));
      d = 16'($urandom);
      start(s, d);
      collect(-1, 0, 16'h0);
      chk++;
      if (c_bits !== expect_bits(s, d))
        $display("FAIL rand_bits: sel=%0d got %h expected %h", s, c_bits, expect_bits(s, d));
      else pass++;
      chk++;
      if (c_busy != expect_busy(s) || c_done != 1 || c_unstable != 0)
        $display("FAIL rand_timing: sel=%0d busy=%0d done=%0d unstable=%0d expected %0d/1/0",
                 s, c_busy, c_done, c_unstable, expect_busy(s));
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_lsb_first();
    test_overrun();
    test_held_load();
    test_back_to_back();
    test_small();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
